snake_motion_ctrl: RTL
======================

Name: snake_motion_ctrl

Overview:
Sequences the player-1 snake head across the playfield. It decodes WASD keycodes into a committed direction, advances the head one cell every STEP_FRAMES frame ticks, and detects wall collisions. It drives snakeX_pos/snakeY_pos and motionFlag, which the sprite renderer uses to pick the W/A/S/D head ROM via its 4:1 palette muxes. It replaces the free-running keycode-to-motionFlag latch with a game-rule-aware controller.

Parameters:
CELL, 24, step size in pixels (equals the head sprite width)
STEP_FRAMES, 8, frame ticks per step (1..255)
X_MIN, 12, minimum legal head centre X
X_MAX, 612, maximum legal head centre X
Y_MIN, 12, minimum legal head centre Y
Y_MAX, 468, maximum legal head centre Y
X_START, 324, head centre X after reset or restart
Y_START, 228, head centre Y after reset or restart

Ports:
Clk  in  1  system clock (frame_tick and keycode are synchronous to it)
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-Clk pulse per frame; every high cycle counts as one tick
keycode  in  8  USB keycode, level-held
restart  in  1  one-Clk pulse; returns to IDLE
snakeX_pos  out  10  head centre X
snakeY_pos  out  10  head centre Y
motionFlag  out  2  committed direction: 00=W(up) 01=A(left) 10=S(down) 11=D(right)
step_pulse  out  1  one-cycle pulse on each accepted step
running  out  1  high in RUN
game_over  out  1  high in DEAD

Behaviour:
- All outputs are registered. While Reset_n=0: state=IDLE, snakeX_pos=X_START, snakeY_pos=Y_START, motionFlag=11, pending_dir=11, frame_cnt=0, step_pulse=0, running=0, game_over=0.
- Key decode: 8'h1A→00, 8'h04→01, 8'h16→10, 8'h07→11. Any other code, including 00, is ignored.
- Reversal rule: a key is a reversal when key_dir XOR motionFlag == 2'b10. In RUN, a reversal is dropped. Any other valid key loads pending_dir. The last valid key before a step wins. Re-accepting a held key is harmless.
- States:
  - IDLE: position held; frame_tick ignored. The first valid key (reversal check skipped) loads pending_dir, clears frame_cnt and moves to RUN on the next edge.
  - RUN: each frame_tick increments frame_cnt. A tick with frame_cnt==STEP_FRAMES-1 is a step edge:
    - frame_cnt←0; motionFlag←pending_dir.
    - Next position = current position moved by ±CELL along the pending_dir axis (W: Y−CELL, S: Y+CELL, A: X−CELL, D: X+CELL).
    - Compute the next position in 11-bit signed so X<CELL cannot wrap.
    - If the next position is outside [X_MIN,X_MAX]×[Y_MIN,Y_MAX]: go to DEAD; position unchanged; motionFlag still commits; no step_pulse.
    - Otherwise: update the position on that same edge; step_pulse=1 for exactly the following cycle.
  - DEAD: all outputs frozen except game_over=1. Keys and ticks are ignored.
- Latency: position and motionFlag change on the Clk edge that samples the step-edge tick. A key and a step tick in the same cycle: the key is evaluated against the pre-step motionFlag and its result is committed by that step.
- restart (any state): go to IDLE with reset values on the next edge. restart has priority over a simultaneous tick or key.
- Reset_n asserted mid-step: everything returns to reset values immediately. No partial update is visible.
- running and game_over are mutually exclusive. Both are 0 in IDLE.

Test Plan:
- Reset, hold keycode=07, apply 8 ticks → state RUN; at the 8th tick snakeX_pos 324→348, Y=228, motionFlag=11, one step_pulse; 7 more ticks → no change.
- In RUN with motionFlag=11, apply keycode=04 (reversal) then 8 ticks → motionFlag stays 11, X advances by 24. Then keycode=1A, 8 ticks → motionFlag=00, Y=204.
- Within one step window apply 1A then 04 → only 04 commits: motionFlag=01, X−24. Same-cycle key=16 with the step tick while moving D → motionFlag=10, Y+24.
- Move A from X=324 for 13 steps → X=12. The 14th step edge → DEAD, game_over=1, X stays 12 (no wrap to ~1000), no step_pulse; further keys and ticks have no effect.
- In DEAD pulse restart concurrently with a tick → IDLE, (324,228), motionFlag=11, game_over=0; ticks alone do not move the head until a key is pressed.
- Assert Reset_n=0 asynchronously on a step-edge tick mid-run → outputs equal reset values before the next Clk edge; step_pulse never asserted.

Source files
------------

// File: rtl/snake_motion_ctrl.sv
// snake_motion_ctrl: player-1 snake head sequencer.
// Decodes WASD keycodes into a committed heading. Advances the head one cell
// every STEP_FRAMES frame ticks. Kills the game when a step would leave the
// legal field.
module snake_motion_ctrl #(
    parameter int CELL        = 24,
    parameter int STEP_FRAMES = 8,
    parameter int X_MIN       = 12,
    parameter int X_MAX       = 612,
    parameter int Y_MIN       = 12,
    parameter int Y_MAX       = 468,
    parameter int X_START     = 324,
    parameter int Y_START     = 228
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic       restart,
    output logic [9:0] snakeX_pos,
    output logic [9:0] snakeY_pos,
    output logic [1:0] motionFlag,
    output logic       step_pulse,
    output logic       running,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DEAD = 2'd2} state_t;

    localparam logic [7:0]         LAST_CNT = 8'(STEP_FRAMES - 1);
    localparam logic signed [10:0] CELL_S   = 11'(CELL);
    localparam logic signed [10:0] XMIN_S   = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S   = 11'(X_MAX);
    localparam logic signed [10:0] YMIN_S   = 11'(Y_MIN);
    localparam logic signed [10:0] YMAX_S   = 11'(Y_MAX);
    localparam logic [9:0]         X_RST    = 10'(X_START);
    localparam logic [9:0]         Y_RST    = 10'(Y_START);

    state_t            state, state_nxt;
    logic [1:0]        pending_dir, pending_nxt, motion_nxt;
    logic [7:0]        frame_cnt, frame_cnt_nxt;
    logic [9:0]        x_nxt, y_nxt;
    logic              step_nxt;
    logic              key_valid, key_ok, step_edge, in_bounds;
    logic [1:0]        key_dir, dir_eff;
    logic signed [10:0] cand_x, cand_y;

    // {valid, direction}: W=00, A=01, S=10, D=11; anything else is ignored
    function automatic logic [2:0] decode_key(input logic [7:0] code);
        case (code)
            8'h1A:   return 3'b1_00;
            8'h04:   return 3'b1_01;
            8'h16:   return 3'b1_10;
            8'h07:   return 3'b1_11;
            default: return 3'b0_00;
        endcase
    endfunction

    // Horizontal candidate in 11-bit signed so a left step near 0 goes negative
    function automatic logic signed [10:0] move_x(input logic [9:0] x, input logic [1:0] d);
        logic signed [10:0] xs;
        xs = $signed({1'b0, x});
        case (d)
            2'b01:   return xs - CELL_S;
            2'b11:   return xs + CELL_S;
            default: return xs;
        endcase
    endfunction

    // Vertical candidate in 11-bit signed so an up step near 0 goes negative
    function automatic logic signed [10:0] move_y(input logic [9:0] y, input logic [1:0] d);
        logic signed [10:0] ys;
        ys = $signed({1'b0, y});
        case (d)
            2'b00:   return ys - CELL_S;
            2'b10:   return ys + CELL_S;
            default: return ys;
        endcase
    endfunction

    // Key filtering, step detection and bounds test of the candidate cell
    always_comb begin
        {key_valid, key_dir} = decode_key(keycode);
        // A reversal flips only the axis-sign bit relative to the committed heading
        key_ok    = key_valid && ((key_dir ^ motionFlag) != 2'b10);
        dir_eff   = key_ok ? key_dir : pending_dir;
        step_edge = frame_tick && (frame_cnt == LAST_CNT);
        cand_x    = move_x(snakeX_pos, dir_eff);
        cand_y    = move_y(snakeY_pos, dir_eff);
        in_bounds = (cand_x >= XMIN_S) && (cand_x <= XMAX_S) &&
                    (cand_y >= YMIN_S) && (cand_y <= YMAX_S);
    end

    // State register plus all registered outputs; async reset clears everything at once
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            snakeX_pos  <= X_RST;
            snakeY_pos  <= Y_RST;
            motionFlag  <= 2'b11;
            pending_dir <= 2'b11;
            frame_cnt   <= 8'd0;
            step_pulse  <= 1'b0;
            running     <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_nxt;
            snakeX_pos  <= x_nxt;
            snakeY_pos  <= y_nxt;
            motionFlag  <= motion_nxt;
            pending_dir <= pending_nxt;
            frame_cnt   <= frame_cnt_nxt;
            step_pulse  <= step_nxt;
            running     <= (state_nxt == RUN);
            game_over   <= (state_nxt == DEAD);
        end
    end

    // Next-state: restart wins over everything, a valid key starts play, a blocked step kills
    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (key_valid) state_nxt = RUN;
                RUN:     if (step_edge && !in_bounds) state_nxt = DEAD;
                DEAD:    state_nxt = DEAD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values of position, heading, pending key, frame counter and step pulse
    always_comb begin
        x_nxt         = snakeX_pos;
        y_nxt         = snakeY_pos;
        motion_nxt    = motionFlag;
        pending_nxt   = pending_dir;
        frame_cnt_nxt = frame_cnt;
        step_nxt      = 1'b0;
        if (restart) begin
            x_nxt         = X_RST;
            y_nxt         = Y_RST;
            motion_nxt    = 2'b11;
            pending_nxt   = 2'b11;
            frame_cnt_nxt = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    // First key is taken without the reversal check
                    if (key_valid) begin
                        pending_nxt   = key_dir;
                        frame_cnt_nxt = 8'd0;
                    end
                end
                RUN: begin
                    pending_nxt = dir_eff;
                    if (step_edge) begin
                        frame_cnt_nxt = 8'd0;
                        motion_nxt    = dir_eff;
                        // An illegal cell leaves the head where it was
                        if (in_bounds) begin
                            x_nxt    = cand_x[9:0];
                            y_nxt    = cand_y[9:0];
                            step_nxt = 1'b1;
                        end
                    end else if (frame_tick) begin
                        frame_cnt_nxt = frame_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
